// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the SRAM slave -- transfer, burst
// and size codes, response codes, the slave FSM state encoding and the
// little-endian byte-lane helper.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_ERR1 = 2'b10;
   localparam logic [1:0] ST_ERR2 = 2'b11;

   // Little-endian lane select. Half accesses pick a lane pair from
   // addr_lo[1] (which also aligns a misaligned half down); sizes above a
   // word fall back to all four lanes.
   function automatic logic [3:0] ahb_byte_en(input logic [1:0] addr_lo,
                                              input logic [2:0] size);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << addr_lo;
         HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal bundle between the master and the SRAM
// slave. The clock and reset are kept outside as plain ports.
interface ahb_sram_slave_if;
   import ahb_pkg::*;

   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HREADY, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HREADY, HRESP, HRDATA
   );

endinterface

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: 2**ADDR_W x 32 synchronous RAM with per-byte write enables
// and a registered read. Lanes written on the same edge as a read of the
// same word are passed into the read register, so a read never returns a
// byte that is being overwritten at that moment.
module ahb_sram_mem
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        wr_be,
   input  logic [31:0]       wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data
);

   logic [31:0] mem_r [2**ADDR_W];
   logic [31:0] rd_data_r;
   logic [31:0] rd_merge_s;

   // Byte-lane writes; the array is intentionally not cleared by reset.
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Merge same-edge write lanes over the stored word for the read path.
   always_comb begin
      rd_merge_s = mem_r[rd_addr];
      for (int i = 0; i < 4; i++) begin
         rd_merge_s[8*i +: 8] = (wr_en && wr_be[i] && (wr_addr == rd_addr)) ?
                                wr_data[8*i +: 8] : mem_r[rd_addr][8*i +: 8];
      end
   end

   // Read register: cleared by reset, otherwise holds until the next read.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rd_data_r <= 32'd0;
      end else if (rd_en) begin
         rd_data_r <= rd_merge_s;
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave in front of a byte-addressable SRAM with
// WAIT wait states per transfer. Optional feature macro AHB_SLAVE_ERR_EN:
// when defined, out-of-range, oversized and misaligned accesses receive the
// two-cycle ERROR response; otherwise addresses alias, accesses are aligned
// down and HRESP stays OKAY.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 0
) (
   input  logic HCLK,
   input  logic HRESET,
   ahb_sram_slave_if.slave bus
);

   logic [1:0]        state_r;
   logic [3:0]        wait_cnt_r;
   logic              hready_r;
   logic              hresp_r;
   logic              pend_valid_r;
   logic              pend_write_r;
   logic [ADDR_W-1:0] pend_addr_r;
   logic [3:0]        pend_be_r;

   logic              accept_s;
   logic              legal_s;
   logic              done_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic [3:0]        be_s;
   logic [ADDR_W-1:0] word_addr_s;
   logic [31:0]       rd_data_s;
   logic              unused_s;

   assign accept_s    = hready_r & bus.HSEL & bus.HTRANS[1];
   assign be_s        = ahb_byte_en(bus.HADDR[1:0], bus.HSIZE);
   assign word_addr_s = bus.HADDR[ADDR_W+1:2];

`ifdef AHB_SLAVE_ERR_EN
   assign legal_s = ((bus.HADDR >> (ADDR_W + 2)) == 32'd0) &&
                    (bus.HSIZE <= HSIZE_WORD) &&
                    !((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) &&
                    !((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00));
`else
   assign legal_s = 1'b1;
`endif

   // A data phase ends on the edge where HREADY is high; reset on that
   // same edge drops the write.
   assign done_s  = hready_r & pend_valid_r;
   assign wr_en_s = done_s & pend_write_r & ~HRESET;
   assign rd_en_s = accept_s & legal_s & ~bus.HWRITE;

   // Slave FSM, wait counter, registered HREADY/HRESP and pending transfer.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r      <= ST_IDLE;
         wait_cnt_r   <= 4'd0;
         hready_r     <= 1'b1;
         hresp_r      <= HRESP_OKAY;
         pend_valid_r <= 1'b0;
         pend_write_r <= 1'b0;
         pend_addr_r  <= {ADDR_W{1'b0}};
         pend_be_r    <= 4'd0;
      end else begin
         case (state_r)
            ST_WAIT: begin
               if (wait_cnt_r == 4'd1) begin
                  state_r    <= ST_IDLE;
                  wait_cnt_r <= 4'd0;
                  hready_r   <= 1'b1;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
`ifdef AHB_SLAVE_ERR_EN
            ST_ERR1: begin
               state_r  <= ST_ERR2;
               hready_r <= 1'b1;
               hresp_r  <= HRESP_ERROR;
            end
`endif
            default: begin
               // Bus is ready here (ST_IDLE or ST_ERR2): a new address may start.
               if (accept_s) begin
                  pend_valid_r <= legal_s;
                  pend_write_r <= bus.HWRITE;
                  pend_addr_r  <= word_addr_s;
                  pend_be_r    <= be_s;
                  if (!legal_s) begin
                     state_r  <= ST_ERR1;
                     hready_r <= 1'b0;
                     hresp_r  <= HRESP_ERROR;
                  end else if (WAIT > 0) begin
                     state_r    <= ST_WAIT;
                     wait_cnt_r <= 4'(WAIT);
                     hready_r   <= 1'b0;
                     hresp_r    <= HRESP_OKAY;
                  end else begin
                     state_r  <= ST_IDLE;
                     hready_r <= 1'b1;
                     hresp_r  <= HRESP_OKAY;
                  end
               end else begin
                  pend_valid_r <= 1'b0;
                  state_r      <= ST_IDLE;
                  hready_r     <= 1'b1;
                  hresp_r      <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   ahb_sram_mem #(.ADDR_W(ADDR_W)) u_mem (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .wr_en   (wr_en_s),
      .wr_addr (pend_addr_r),
      .wr_be   (pend_be_r),
      .wr_data (bus.HWDATA),
      .rd_en   (rd_en_s),
      .rd_addr (word_addr_s),
      .rd_data (rd_data_s)
   );

   assign bus.HREADY = hready_r;
   assign bus.HRESP  = hresp_r;
   assign bus.HRDATA = rd_data_s;

   // Burst, protection and lock are accepted but carry no meaning here.
   assign unused_s = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0],
                       bus.HADDR[31:ADDR_W+2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: two slaves (WAIT=0 and WAIT=2) share one bus master
// model; a byte-array reference memory predicts every read, and each data
// phase is checked for wait-state count, response and read data.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   localparam int AW    = 10;
   localparam int NWORD = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   bit   sel;

   logic        m_hsel;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [31:0] m_hwdata;

   logic        obs_hready;
   logic        obs_hresp;
   logic [31:0] obs_hrdata;

   int n_checks;
   int n_errors;

   // Reference memory, one byte array per slave instance.
   logic [7:0] mem_m [2][NWORD*4];

   bit          dp_valid;
   bit          dp_write;
   bit          dp_err;
   logic [31:0] dp_addr;
   logic [2:0]  dp_size;
   logic [31:0] dp_wdata;
   int          dp_low;
   logic [31:0] last_rdata;

   // Free-running bus clock.
   always #5 clk = ~clk;

   ahb_sram_slave_if bus0 ();
   ahb_sram_slave_if bus1 ();

   assign bus0.HSEL      = m_hsel & ~sel;
   assign bus1.HSEL      = m_hsel & sel;
   assign bus0.HADDR     = m_haddr;
   assign bus1.HADDR     = m_haddr;
   assign bus0.HTRANS    = m_htrans;
   assign bus1.HTRANS    = m_htrans;
   assign bus0.HWRITE    = m_hwrite;
   assign bus1.HWRITE    = m_hwrite;
   assign bus0.HSIZE     = m_hsize;
   assign bus1.HSIZE     = m_hsize;
   assign bus0.HBURST    = HBURST_INCR;
   assign bus1.HBURST    = HBURST_INCR;
   assign bus0.HPROT     = 4'b0011;
   assign bus1.HPROT     = 4'b0011;
   assign bus0.HMASTLOCK = 1'b0;
   assign bus1.HMASTLOCK = 1'b0;
   assign bus0.HWDATA    = m_hwdata;
   assign bus1.HWDATA    = m_hwdata;

   assign obs_hready = sel ? bus1.HREADY : bus0.HREADY;
   assign obs_hresp  = sel ? bus1.HRESP  : bus0.HRESP;
   assign obs_hrdata = sel ? bus1.HRDATA : bus0.HRDATA;

   ahb_sram_slave #(.ADDR_W(AW), .WAIT(0)) dut0 (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus0.slave)
   );

   ahb_sram_slave #(.ADDR_W(AW), .WAIT(2)) dut1 (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus1.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLAVE_ERR_EN
      return ((a >> (AW + 2)) != 32'd0) || (s > 3'd2) ||
             ((s == 3'd1) && a[0]) || ((s == 3'd2) && (a[1:0] != 2'd0));
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_word(input logic [31:0] a);
      return int'((a >> 2) % NWORD);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int w;
      w = model_word(a);
      return {mem_m[sel][4*w+3], mem_m[sel][4*w+2], mem_m[sel][4*w+1], mem_m[sel][4*w]};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      int w;
      int nb;
      int first;
      w     = model_word(a);
      nb    = (s == 3'd0) ? 1 : ((s == 3'd1) ? 2 : 4);
      first = (int'(a % 4) / nb) * nb;
      for (int k = first; k < first + nb; k++) begin
         mem_m[sel][4*w+k] = d[8*k +: 8];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic complete_dp();
      int exp_low;
      exp_low = dp_err ? 1 : (sel ? 2 : 0);
      check_eq("wait_states", dp_low, exp_low);
      check_eq("hresp_done", {31'd0, obs_hresp}, {31'd0, dp_err});
      if (!dp_err) begin
         if (dp_write) begin
            model_write(dp_addr, dp_size, dp_wdata);
         end else begin
            last_rdata = obs_hrdata;
            check_eq("hrdata", obs_hrdata, model_read(dp_addr));
         end
      end
      dp_valid = 1'b0;
   endtask

   // Called at a negedge: finishes the current data phase, then drives the
   // next address phase and advances one accepting edge.
   task automatic bus_cycle(input bit hs, input logic [1:0] t, input bit wr,
                            input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      int guard;
      guard = 0;
      if (dp_valid) m_hwdata = dp_wdata;
      while (!obs_hready && guard < 40) begin
         if (dp_valid) begin
            dp_low++;
            check_eq("hresp_wait", {31'd0, obs_hresp}, {31'd0, dp_err});
         end else begin
            check_eq("hready_idle", {31'd0, obs_hready}, 32'd1);
         end
         guard++;
         tick();
      end
      if (!obs_hready) begin
         check_eq("hready_timeout", {31'd0, obs_hready}, 32'd1);
         dp_valid = 1'b0;
      end else if (dp_valid) begin
         complete_dp();
      end else begin
         check_eq("hresp_idle", {31'd0, obs_hresp}, 32'd0);
      end
      m_hsel   = hs;
      m_htrans = t;
      m_hwrite = wr;
      m_haddr  = a;
      m_hsize  = s;
      if (hs && t[1]) begin
         dp_valid = 1'b1;
         dp_write = wr;
         dp_addr  = a;
         dp_size  = s;
         dp_wdata = d;
         dp_err   = is_illegal(a, s);
         dp_low   = 0;
      end
      tick();
   endtask

   task automatic wr_xfer(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      bus_cycle(1'b1, HTRANS_NONSEQ, 1'b1, a, s, d);
   endtask

   task automatic rd_xfer(input logic [31:0] a, input logic [2:0] s);
      bus_cycle(1'b1, HTRANS_NONSEQ, 1'b0, a, s, 32'd0);
   endtask

   task automatic flush();
      bus_cycle(1'b0, HTRANS_IDLE, 1'b0, 32'd0, HSIZE_WORD, 32'd0);
   endtask

   task automatic random_run(input int n);
      int          kind;
      logic [31:0] a;
      logic [2:0]  s;
      logic [1:0]  t;
      for (int i = 0; i < n; i++) begin
         kind = int'($urandom_range(0, 9));
         a    = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
         s = 3'($urandom_range(0, 3));
         t = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
         case (kind)
            0:       bus_cycle(1'b1, HTRANS_IDLE, 1'b0, a, s, 32'd0);
            1:       bus_cycle(1'b1, HTRANS_BUSY, 1'b0, a, s, 32'd0);
            2:       bus_cycle(1'b0, t, 1'b1, a, s, $urandom);
            default: bus_cycle(1'b1, t, kind[0], a, s, $urandom);
         endcase
      end
      flush();
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   // Main sequence: reset, preload, directed plan cases, random traffic.
   initial begin
      n_checks   = 0;
      n_errors   = 0;
      sel        = 1'b0;
      dp_valid   = 1'b0;
      dp_low     = 0;
      last_rdata = 32'd0;
      m_hsel     = 1'b0;
      m_htrans   = HTRANS_IDLE;
      m_hwrite   = 1'b0;
      m_haddr    = 32'd0;
      m_hsize    = HSIZE_WORD;
      m_hwdata   = 32'd0;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_hready0", {31'd0, bus0.HREADY}, 32'd1);
      check_eq("rst_hresp0",  {31'd0, bus0.HRESP},  32'd0);
      check_eq("rst_hrdata0", bus0.HRDATA, 32'd0);
      check_eq("rst_hready1", {31'd0, bus1.HREADY}, 32'd1);
      check_eq("rst_hresp1",  {31'd0, bus1.HRESP},  32'd0);
      check_eq("rst_hrdata1", bus1.HRDATA, 32'd0);
      rst = 1'b0;

      for (int u = 0; u < 2; u++) begin
         sel = u[0];
         for (int w = 0; w < 32; w++) wr_xfer(32'(w * 4), HSIZE_WORD, $urandom);
         flush();
      end

      sel = 1'b0;
      wr_xfer(32'h10, HSIZE_WORD, 32'hDEADBEEF);
      rd_xfer(32'h10, HSIZE_WORD);
      flush();
      check_eq("plan_deadbeef", last_rdata, 32'hDEADBEEF);
      wr_xfer(32'h10, HSIZE_WORD, 32'h11223344);
      wr_xfer(32'h13, HSIZE_BYTE, 32'hAA000000);
      rd_xfer(32'h10, HSIZE_WORD);
      flush();
      check_eq("plan_byte", last_rdata, 32'hAA223344);
      wr_xfer(32'h40, HSIZE_WORD, 32'h5555AAAA);
      rd_xfer(32'h40, HSIZE_WORD);
      flush();
      check_eq("plan_fwd", last_rdata, 32'h5555AAAA);
      wr_xfer(32'h44, HSIZE_WORD, 32'h01020304);
      wr_xfer(32'h46, HSIZE_HALF, 32'hBEEF0000);
      rd_xfer(32'h44, HSIZE_WORD);
      flush();
      check_eq("half_fwd", last_rdata, 32'hBEEF0304);
      wr_xfer(32'h0, HSIZE_WORD, 32'h0000C0DE);
`ifdef AHB_SLAVE_ERR_EN
      wr_xfer(32'h1000, HSIZE_WORD, 32'hFFFFFFFF);
      rd_xfer(32'h0, HSIZE_WORD);
      flush();
      check_eq("err_no_commit", last_rdata, 32'h0000C0DE);
`else
      wr_xfer(32'h1008, HSIZE_WORD, 32'h600DF00D);
      rd_xfer(32'h8, HSIZE_WORD);
      wr_xfer(32'h0D, HSIZE_WORD, 32'h12345678);
      rd_xfer(32'hC, HSIZE_WORD);
      flush();
      check_eq("align_down", last_rdata, 32'h12345678);
      rd_xfer(32'h8, HSIZE_WORD);
      flush();
      check_eq("alias", last_rdata, 32'h600DF00D);
`endif
      random_run(150);

      sel = 1'b1;
      wr_xfer(32'h20, HSIZE_WORD, 32'h0BADC0DE);
      rd_xfer(32'h20, HSIZE_WORD);
      flush();
      check_eq("plan_wait2", last_rdata, 32'h0BADC0DE);
      wr_xfer(32'h20, HSIZE_WORD, 32'hCAFEF00D);
      m_hwdata = 32'hCAFEF00D;
      m_hsel   = 1'b0;
      m_htrans = HTRANS_IDLE;
      check_eq("rst_mid_wait", {31'd0, obs_hready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst_mid_hready", {31'd0, obs_hready}, 32'd1);
      check_eq("rst_mid_hresp",  {31'd0, obs_hresp},  32'd0);
      check_eq("rst_mid_hrdata", obs_hrdata, 32'd0);
      dp_valid = 1'b0;
      rd_xfer(32'h20, HSIZE_WORD);
      flush();
      check_eq("rst_mid_nocommit", last_rdata, 32'h0BADC0DE);
      random_run(150);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
